// File: rtl/ir_cmd_sequencer.sv
// NEC frame validator, key-repeat sequencer and command FIFO.
// Bridges infrared_rx frames to a valid/ready command byte stream.
module ir_cmd_sequencer #(
   parameter int         CLK_MHZ         = 12,
   parameter bit         CHECK_ADDR      = 1'b1,
   parameter logic [7:0] ADDR            = 8'h00,
   parameter int         REPEAT_DELAY_MS = 300,
   parameter int         REPEAT_RATE_MS  = 100,
   parameter int         RELEASE_MS      = 150,
   parameter int         FIFO_DEPTH      = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] IR_DATA,
   input  logic        IR_DATA_READY,
   input  logic [7:0]  IR_ERROR_CODE,
   output logic [7:0]  CMD_DATA,
   output logic        CMD_VALID,
   input  logic        CMD_READY,
   output logic        KEY_HELD,
   output logic        FRAME_ERR,
   output logic        OVERFLOW
);

   localparam int TICK_N = CLK_MHZ * 1000;
   localparam int PW     = $clog2(TICK_N);
   localparam int AW     = $clog2(FIFO_DEPTH);

   localparam logic [PW-1:0] TICK_MAX  = PW'(TICK_N - 1);
   localparam logic [15:0]   DELAY_T   = 16'(REPEAT_DELAY_MS);
   localparam logic [15:0]   RATE_T    = 16'(REPEAT_RATE_MS);
   localparam logic [15:0]   RELEASE_T = 16'(RELEASE_MS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HELD = 2'd1,
      S_AUTO = 2'd2
   } state_t;

   logic [PW-1:0] presc;
   logic          tick;

   logic          fv;
   logic [7:0]    fcmd;
   logic          frame_err;
   logic          frame_ok;

   state_t        state;
   logic [7:0]    last_cmd;
   logic [15:0]   t_push;
   logic [15:0]   t_frame;
   logic          key_held;
   logic          match;
   logic          push;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          empty;
   logic          full;
   logic          pop;
   logic          ovf;

   // Millisecond prescaler
   assign tick = (presc == TICK_MAX);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   assign frame_ok = (IR_ERROR_CODE == 8'h00)
                  && (IR_DATA[15:8] == ~IR_DATA[7:0])
                  && (IR_DATA[31:24] == ~IR_DATA[23:16])
                  && (!CHECK_ADDR || (IR_DATA[31:24] == ADDR));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fv        <= 1'b0;
         fcmd      <= 8'h00;
         frame_err <= 1'b0;
      end else begin
         fv        <= IR_DATA_READY & frame_ok;
         frame_err <= IR_DATA_READY & ~frame_ok;
         if (IR_DATA_READY) begin
            fcmd <= IR_DATA[15:8];
         end
      end
   end

   assign match = (fcmd == last_cmd);

   always_comb begin
      push = 1'b0;
      if (fv) begin
         unique case (state)
            S_IDLE:  push = 1'b1;
            S_HELD:  push = !match || (t_push >= DELAY_T);
            S_AUTO:  push = !match || (t_push >= RATE_T);
            default: push = 1'b0;
         endcase
      end
   end

   // Frame handling takes priority over the release timeout
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= S_IDLE;
         last_cmd <= 8'h00;
         t_push   <= 16'h0000;
         t_frame  <= 16'h0000;
         key_held <= 1'b0;
      end else begin
         if (tick) begin
            if (t_push != 16'hFFFF) t_push <= t_push + 16'd1;
            if (t_frame != 16'hFFFF) t_frame <= t_frame + 16'd1;
         end
         unique case (state)
            S_IDLE: begin
               if (fv) begin
                  last_cmd <= fcmd;
                  t_push   <= 16'h0000;
                  t_frame  <= 16'h0000;
                  state    <= S_HELD;
                  key_held <= 1'b1;
               end
            end
            S_HELD, S_AUTO: begin
               if (fv) begin
                  if (match) begin
                     t_frame <= 16'h0000;
                     if (push) begin
                        t_push <= 16'h0000;
                        state  <= S_AUTO;
                     end
                  end else begin
                     last_cmd <= fcmd;
                     t_push   <= 16'h0000;
                     t_frame  <= 16'h0000;
                     state    <= S_HELD;
                  end
               end else if (t_frame >= RELEASE_T) begin
                  state    <= S_IDLE;
                  key_held <= 1'b0;
               end
            end
            default: begin
               state    <= S_IDLE;
               key_held <= 1'b0;
            end
         endcase
      end
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW])
               && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && CMD_READY;

   // A push into a full FIFO lands in the slot being popped
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= 8'h00;
         end
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && (!full || pop)) begin
            mem[wr_ptr[AW-1:0]] <= fcmd;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (push && full && !pop) begin
            ovf <= 1'b1;
         end
      end
   end

   assign CMD_DATA  = mem[rd_ptr[AW-1:0]];
   assign CMD_VALID = !empty;
   assign KEY_HELD  = key_held;
   assign FRAME_ERR = frame_err;
   assign OVERFLOW  = ovf;

endmodule

// File: tb/tb_ir_cmd_sequencer.sv
// Directed self-checking bench for ir_cmd_sequencer.
// Timings are scaled down (1 ms = 1000 clocks) to keep runs short.
module tb_ir_cmd_sequencer;

   localparam int DLY  = 10;
   localparam int RATE = 3;
   localparam int REL  = 5;
   localparam int MS   = 1000;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [31:0] IR_DATA = 32'h0;
   logic        IR_DATA_READY = 1'b0;
   logic [7:0]  IR_ERROR_CODE = 8'h00;
   logic [7:0]  CMD_DATA;
   logic        CMD_VALID;
   logic        CMD_READY = 1'b0;
   logic        KEY_HELD;
   logic        FRAME_ERR;
   logic        OVERFLOW;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [7:0] pop_q[$];
   int         pop_t[$];

   ir_cmd_sequencer #(
      .CLK_MHZ(1),
      .CHECK_ADDR(1'b1),
      .ADDR(8'h00),
      .REPEAT_DELAY_MS(DLY),
      .REPEAT_RATE_MS(RATE),
      .RELEASE_MS(REL),
      .FIFO_DEPTH(4)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .IR_DATA(IR_DATA),
      .IR_DATA_READY(IR_DATA_READY),
      .IR_ERROR_CODE(IR_ERROR_CODE),
      .CMD_DATA(CMD_DATA),
      .CMD_VALID(CMD_VALID),
      .CMD_READY(CMD_READY),
      .KEY_HELD(KEY_HELD),
      .FRAME_ERR(FRAME_ERR),
      .OVERFLOW(OVERFLOW)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin
      if (RST_N && CMD_VALID && CMD_READY) begin
         pop_q.push_back(CMD_DATA);
         pop_t.push_back(cyc);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send_frame(input logic [31:0] d, input logic [7:0] e);
      step(1);
      IR_DATA       = d;
      IR_ERROR_CODE = e;
      IR_DATA_READY = 1'b1;
      step(1);
      IR_DATA_READY = 1'b0;
      IR_ERROR_CODE = 8'h00;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      step(2);
      RST_N = 1'b1;
      step(1);
      pop_q.delete();
      pop_t.delete();
   endtask

   task automatic test_reset();
      step(3);
      checks++;
      if ({CMD_VALID, KEY_HELD, FRAME_ERR, OVERFLOW} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0000",
                  {CMD_VALID, KEY_HELD, FRAME_ERR, OVERFLOW});
      end
      checks++;
      if (CMD_DATA !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: got %h want 00", CMD_DATA);
      end
      RST_N = 1'b1;
      step(3);
      checks++;
      if ({CMD_VALID, KEY_HELD, FRAME_ERR, OVERFLOW} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle: got %b want 0000",
                  {CMD_VALID, KEY_HELD, FRAME_ERR, OVERFLOW});
      end
   endtask

   task automatic test_single_press();
      do_reset();
      CMD_READY = 1'b1;
      send_frame(32'h00FF45BA, 8'h00);
      @(negedge CLK);
      checks++;
      if (CMD_VALID !== 1'b0) begin
         errors++;
         $display("FAIL single_lat1: got valid=%b want 0", CMD_VALID);
      end
      @(negedge CLK);
      checks++;
      if (CMD_VALID !== 1'b1 || CMD_DATA !== 8'h45) begin
         errors++;
         $display("FAIL single_push: got valid=%b data=%h want 1/45",
                  CMD_VALID, CMD_DATA);
      end
      checks++;
      if (KEY_HELD !== 1'b1) begin
         errors++;
         $display("FAIL single_held: got %b want 1", KEY_HELD);
      end
      @(negedge CLK);
      checks++;
      if (CMD_VALID !== 1'b0) begin
         errors++;
         $display("FAIL single_pop: got valid=%b want 0", CMD_VALID);
      end
      repeat (3400) @(negedge CLK);
      checks++;
      if (KEY_HELD !== 1'b1) begin
         errors++;
         $display("FAIL single_still_held: got %b want 1", KEY_HELD);
      end
      repeat (2000) @(negedge CLK);
      checks++;
      if (KEY_HELD !== 1'b0) begin
         errors++;
         $display("FAIL single_release: got %b want 0", KEY_HELD);
      end
      checks++;
      if (pop_q.size() != 1) begin
         errors++;
         $display("FAIL single_count: got %0d want 1", pop_q.size());
      end
   endtask

   task automatic test_auto_repeat();
      int exp_k[5] = '{0, 3, 4, 5, 6};
      do_reset();
      CMD_READY = 1'b1;
      for (int i = 0; i < 7; i++) begin
         send_frame(32'h00FF45BA, 8'h00);
         step(4 * MS - 2);
      end
      checks++;
      if (pop_q.size() != 5) begin
         errors++;
         $display("FAIL auto_count: got %0d want 5", pop_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (pop_q[i] !== 8'h45 ||
                pop_t[i] - pop_t[0] != exp_k[i] * 4 * MS) begin
               errors++;
               $display("FAIL auto_push%0d: got %h at +%0d want 45 at +%0d",
                        i, pop_q[i], pop_t[i] - pop_t[0], exp_k[i] * 4 * MS);
            end
         end
      end
   endtask

   task automatic test_rejection();
      logic [31:0] fr[3] = '{32'h00FF4545, 32'h00FF45BA, 32'h10EF45BA};
      logic [7:0]  er[3] = '{8'h00, 8'h03, 8'h00};
      do_reset();
      CMD_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send_frame(fr[i], er[i]);
         @(negedge CLK);
         checks++;
         if (FRAME_ERR !== 1'b1) begin
            errors++;
            $display("FAIL reject%0d_err: got %b want 1", i, FRAME_ERR);
         end
         @(negedge CLK);
         checks++;
         if (FRAME_ERR !== 1'b0 || KEY_HELD !== 1'b0) begin
            errors++;
            $display("FAIL reject%0d_after: got err=%b held=%b want 0/0",
                     i, FRAME_ERR, KEY_HELD);
         end
      end
      step(3);
      checks++;
      if (pop_q.size() != 0 || CMD_VALID !== 1'b0) begin
         errors++;
         $display("FAIL reject_nopush: got %0d pops valid=%b want 0/0",
                  pop_q.size(), CMD_VALID);
      end
   endtask

   task automatic test_key_change();
      do_reset();
      CMD_READY = 1'b1;
      send_frame(32'h00FF45BA, 8'h00);
      step(4 * MS - 2);
      send_frame(32'h00FF46B9, 8'h00);
      step(5);
      checks++;
      if (pop_q.size() != 2) begin
         errors++;
         $display("FAIL change_count: got %0d want 2", pop_q.size());
      end else begin
         checks++;
         if (pop_q[0] !== 8'h45 || pop_q[1] !== 8'h46) begin
            errors++;
            $display("FAIL change_data: got %h %h want 45 46",
                     pop_q[0], pop_q[1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] k;
      do_reset();
      CMD_READY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         k = 8'h11 + 8'(i);
         send_frame({8'h00, 8'hFF, k, ~k}, 8'h00);
         step(6 * MS - 2);
      end
      checks++;
      if (OVERFLOW !== 1'b0 || CMD_VALID !== 1'b1) begin
         errors++;
         $display("FAIL bp_four: got ovf=%b valid=%b want 0/1",
                  OVERFLOW, CMD_VALID);
      end
      k = 8'h15;
      send_frame({8'h00, 8'hFF, k, ~k}, 8'h00);
      step(3);
      checks++;
      if (OVERFLOW !== 1'b1 || CMD_DATA !== 8'h11) begin
         errors++;
         $display("FAIL bp_overflow: got ovf=%b head=%h want 1/11",
                  OVERFLOW, CMD_DATA);
      end
      CMD_READY = 1'b1;
      step(6);
      checks++;
      if (pop_q.size() != 4) begin
         errors++;
         $display("FAIL bp_drain_count: got %0d want 4", pop_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (pop_q[i] !== 8'h11 + 8'(i) || pop_t[i] != pop_t[0] + i) begin
               errors++;
               $display("FAIL bp_drain%0d: got %h at +%0d want %h at +%0d",
                        i, pop_q[i], pop_t[i] - pop_t[0], 8'h11 + 8'(i), i);
            end
         end
      end
      checks++;
      if (CMD_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin
         errors++;
         $display("FAIL bp_empty: got valid=%b ovf=%b want 0/1",
                  CMD_VALID, OVERFLOW);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      CMD_READY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send_frame(32'h00FF45BA, 8'h00);
         if (i < 3) step(4 * MS - 2);
      end
      step(3);
      checks++;
      if (KEY_HELD !== 1'b1 || CMD_VALID !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre: got held=%b valid=%b want 1/1",
                  KEY_HELD, CMD_VALID);
      end
      #2;
      RST_N = 1'b0;
      #1;
      checks++;
      if ({CMD_VALID, KEY_HELD, OVERFLOW} !== 3'b000) begin
         errors++;
         $display("FAIL arst_now: got %b want 000",
                  {CMD_VALID, KEY_HELD, OVERFLOW});
      end
      step(2);
      RST_N = 1'b1;
      step(1);
      send_frame(32'h00FF46B9, 8'h00);
      @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (CMD_VALID !== 1'b1 || CMD_DATA !== 8'h46) begin
         errors++;
         $display("FAIL arst_fresh: got valid=%b data=%h want 1/46",
                  CMD_VALID, CMD_DATA);
      end
      step(1);
      CMD_READY = 1'b1;
      step(3);
      checks++;
      if (CMD_VALID !== 1'b0) begin
         errors++;
         $display("FAIL arst_discard: got valid=%b want 0", CMD_VALID);
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_auto_repeat();
      test_rejection();
      test_key_change();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
